irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Prioritising interrupt controller between up to 8 peripheral interrupt sources and the CPU's single irq_ip.
//  - Latches rising edges into a pending register and applies a per-source mask.
//  - Presents the highest-priority pending source as a vector.
//  - Sequences one interrupt at a time: request -> ACK -> in-service -> EOI.
//  - Register-mapped on the 8-bit peripheral bus (addr/data/wr_en/rd_en).
// PARAMETERS
//  N_SRC      8      number of interrupt sources, 1..8; source 0 = highest priority
//  BASE_ADDR  8'h10  peripheral address of register offset 0; occupies BASE_ADDR..BASE_ADDR+3
// PORTS
//  clk_ip        in   1      clock, all state updates on posedge
//  reset         in   1      synchronous, active-high reset
//  src_ip        in   N_SRC  interrupt source lines, rising-edge sensitive
//  bus_addr_ip   in   8      peripheral address
//  bus_wdata_ip  in   8      write data (CPU W register)
//  bus_wr_en_ip  in   1      write strobe, one cycle per store
//  bus_rd_en_ip  in   1      read strobe
//  bus_rdata_op  out  8      read data, combinational; 8'h00 when not selected
//  bus_sel_op    out  1      1 when bus_rd_en_ip=1 and bus_addr_ip is in this block's window
//  irq_op        out  1      interrupt request to CPU irq_ip, registered
//  active_id_op  out  3      vector id: candidate in REQ, frozen id in SERVICE
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   +0 PEND  R/W1C; bit i set on a src_ip[i] rising edge.
//   +1 MASK  R/W; 1 = source enabled.
//   +2 VECT  R; {valid, 4'b0, id[2:0]}, valid = (state==REQ). Reads have no side effects.
//   +3 CTRL  W: bit0 GIE (stored), bit1 ACK (strobe), bit2 EOI (strobe). R: {6'b0, in_service, GIE}.
//  Bus rules:
//   - Writes take effect at the posedge where bus_wr_en_ip=1.
//   - Addresses outside the window have no effect.
//   - PEND/MASK bits >= N_SRC ignore writes and read 0.
//  Reset values: PEND=0, MASK=0, GIE=0, src_d=0, state=IDLE, irq_op=0, active_id_op=0.
//   - A source already high on the first cycle after reset registers one edge.
//  Edge/priority rules:
//   - edge = src & ~src_d.
//   - An edge setting a PEND bit wins over a same-cycle W1C or EOI clear of that bit.
//   - Candidate id = lowest set index of (PEND & MASK).
//  FSM (irq_op = registered (state==REQ)):
//   IDLE    -> REQ when GIE && |(PEND&MASK); candidate id latched.
//   REQ     id re-evaluated every cycle, so a higher-priority arrival preempts before ACK.
//           -> IDLE if GIE=0 or (PEND&MASK)==0 (withdrawn request, no ACK needed).
//           -> SERVICE on ACK write; id frozen.
//   SERVICE irq_op=0. ACK ignored. EOI clears PEND[id] -> IDLE.
//           Further edges only pend.
//   EOI in IDLE/REQ and ACK in IDLE/SERVICE are ignored.
//   ACK and EOI written together: ACK only. EOI never completes in the same write as ACK.
//  Latency: src_ip rise sampled at edge k -> PEND set at k -> REQ at k+1 -> irq_op=1 after k+1.
//   EOI at edge m -> IDLE at m -> REQ earliest at m+1 if more sources are pending.
//  Reset asserted mid-sequence returns all state to reset values next edge. Pending edges are lost.
// CONFIGURATION
//  IRQ_CTRL_SYNC_EN defined:
//   - Each src_ip bit passes through a 2-flop synchronizer (reset 0) before edge detection.
//   - Source-to-irq_op latency grows by 2 cycles, for asynchronous sources.
//  IRQ_CTRL_SYNC_EN undefined: src_ip is used directly; sources must be clk_ip-synchronous.
// STRUCTURE
//  Package irq_ctrl_pkg:
//   - register offsets PEND/MASK/VECT/CTRL
//   - CTRL bit indices GIE/ACK/EOI
//   - FSM state encoding IDLE/REQ/SERVICE
//  Sub-module irq_prio_enc: combinational N_SRC-bit lowest-index-first encoder -> {valid, id[2:0]}.
//  Top level: synchronizer/edge detect, PEND/MASK/CTRL registers, FSM, read mux.
// TESTING
//  1. MASK=0x04, CTRL=0x01, pulse src[2] -> PEND=0x04; irq_op=1 2 cycles after the edge; VECT=0x82.
//  2. src[5] and src[1] together, MASK=0xFF, GIE=1 -> VECT=0x81. ACK -> irq_op=0, CTRL reads 0x03.
//     EOI -> PEND=0x20, REQ re-entered with VECT=0x85.
//  3. In REQ with id=3, raise src[0] before ACK -> VECT changes 0x83 -> 0x80 next cycle.
//  4. In REQ, write PEND=0x08 (W1C of the only source) -> IDLE, irq_op drops, VECT=0x03.
//  5. Same-cycle src[4] edge and W1C of PEND bit 4 -> PEND bit 4 stays 1.
//     ACK+EOI written together (CTRL=0x07) -> SERVICE, PEND unchanged.
//  6. Assert reset while in SERVICE -> PEND=MASK=0, irq_op=0, CTRL reads 0x00.
//     With IRQ_CTRL_SYNC_EN, test 1 latency is 4 cycles.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register offsets, CTRL bit indices and FSM encoding for irq_ctrl
package irq_ctrl_pkg;

  localparam logic [1:0] OFS_PEND = 2'd0;
  localparam logic [1:0] OFS_MASK = 2'd1;
  localparam logic [1:0] OFS_VECT = 2'd2;
  localparam logic [1:0] OFS_CTRL = 2'd3;

  localparam int CTRL_GIE = 0;
  localparam int CTRL_ACK = 1;
  localparam int CTRL_EOI = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - 8-bit peripheral bus between CPU (master) and irq_ctrl (slave)
interface irq_ctrl_if;
  logic [7:0] bus_addr_ip;
  logic [7:0] bus_wdata_ip;
  logic       bus_wr_en_ip;
  logic       bus_rd_en_ip;
  logic [7:0] bus_rdata_op;
  logic       bus_sel_op;

  modport master (
    output bus_addr_ip, bus_wdata_ip, bus_wr_en_ip, bus_rd_en_ip,
    input  bus_rdata_op, bus_sel_op
  );

  modport slave (
    input  bus_addr_ip, bus_wdata_ip, bus_wr_en_ip, bus_rd_en_ip,
    output bus_rdata_op, bus_sel_op
  );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// rtl/irq_ctrl_prio_enc.sv - lowest-index-first priority encoder (index 0 wins)
module irq_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [2:0]       id
);

  always_comb begin
    valid = |req;
    id    = 3'd0;
    // Scan downwards so the lowest set index is the last to assign.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritising interrupt controller, request/ACK/service/EOI sequencing
// IRQ_CTRL_SYNC_EN: when defined, src_ip passes through a 2-flop synchronizer first.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int         N_SRC     = 8,
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic             clk_ip,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_ip,
  irq_ctrl_if.slave        bus,
  output logic             irq_op,
  output logic [2:0]       active_id_op
);

  localparam logic [7:0] SRC_MASK = 8'((16'd1 << N_SRC) - 16'd1);

  logic [7:0] src8, src_s, src_d, edge_det;
  logic [7:0] pend, pend_n, mask, pm, pend_w1c, eoi_clr;
  logic [7:0] offset, rd_mux;
  logic [1:0] ofs;
  logic       gie, in_win, wr_hit, ctrl_wr, ack, eoi;
  logic       cand_valid;
  logic [2:0] cand_id, id_q, id_n;
  irq_state_t state, state_n;

  always_comb begin
    src8           = '0;
    src8[N_SRC-1:0] = src_ip;
  end

`ifdef IRQ_CTRL_SYNC_EN
  logic [7:0] sync1, sync2;
  always_ff @(posedge clk_ip) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src8;
      sync2 <= sync1;
    end
  end
  assign src_s = sync2;
`else
  assign src_s = src8;
`endif

  assign edge_det = src_s & ~src_d & SRC_MASK;

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
  assign offset  = bus.bus_addr_ip - BASE_ADDR;
  assign in_win  = (offset < 8'd4);
  assign ofs     = offset[1:0];
  assign wr_hit  = bus.bus_wr_en_ip && in_win;
  assign ctrl_wr = wr_hit && (ofs == OFS_CTRL);
  assign ack     = ctrl_wr && bus.bus_wdata_ip[CTRL_ACK];
  assign eoi     = ctrl_wr && bus.bus_wdata_ip[CTRL_EOI] && !bus.bus_wdata_ip[CTRL_ACK];

  assign pend_w1c = (wr_hit && (ofs == OFS_PEND)) ? (bus.bus_wdata_ip & SRC_MASK) : 8'h00;
  assign eoi_clr  = (state == SERVICE && eoi) ? (8'd1 << id_q) : 8'h00;
  // New edges are OR-ed in last so they survive a same-cycle clear.
  assign pend_n   = (pend & ~pend_w1c & ~eoi_clr) | edge_det;
  assign pm       = pend & mask;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req   (pm[N_SRC-1:0]),
    .valid (cand_valid),
    .id    (cand_id)
  );

  always_comb begin
    state_n = state;
    id_n    = id_q;
    case (state)
      IDLE: begin
        if (gie && cand_valid) begin
          state_n = REQ;
          id_n    = cand_id;
        end
      end
      REQ: begin
        if (!gie || !cand_valid) state_n = IDLE;
        else if (ack)            state_n = SERVICE;
        else                     id_n    = cand_id;
      end
      SERVICE: begin
        if (eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_ip) begin
    if (reset) begin
      src_d  <= '0;
      pend   <= '0;
      mask   <= '0;
      gie    <= 1'b0;
      state  <= IDLE;
      id_q   <= 3'd0;
      irq_op <= 1'b0;
    end else begin
      src_d  <= src_s;
      pend   <= pend_n;
      if (wr_hit && (ofs == OFS_MASK)) mask <= bus.bus_wdata_ip & SRC_MASK;
      if (ctrl_wr) gie <= bus.bus_wdata_ip[CTRL_GIE];
      state  <= state_n;
      id_q   <= id_n;
      irq_op <= (state_n == REQ);
    end
  end

  assign active_id_op = id_q;

  always_comb begin
    rd_mux = 8'h00;
    case (ofs)
      OFS_PEND: rd_mux = pend;
      OFS_MASK: rd_mux = mask;
      OFS_VECT: rd_mux = {(state == REQ), 4'b0000, id_q};
      OFS_CTRL: rd_mux = {6'b000000, (state == SERVICE), gie};
      default:  rd_mux = 8'h00;
    endcase
  end

  assign bus.bus_sel_op   = bus.bus_rd_en_ip && in_win;
  assign bus.bus_rdata_op = bus.bus_sel_op ? rd_mux : 8'h00;

endmodule
